// File: rtl/score_display_scan.sv
// Score-to-display feeder: saturating binary-to-BCD (double-dabble, one step per clock)
// followed by a free-running 4-digit anode scan with optional leading-zero blanking.
`timescale 1ns/1ps
module score_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  num,
    output logic [3:0]  an
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [1:0]    r_state;
    logic [3:0]    r_iter;
    logic [29:0]   r_shift;
    logic          r_pending;
    logic [13:0]   r_pend_val;
    logic [15:0]   r_digits;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_slot;

    logic [13:0]   w_score_sat;
    logic [29:0]   w_adj;
    logic [3:0]    w_digit;
    logic          w_lz;
    logic [3:0]    w_slot_num;

    assign w_score_sat = (score > 14'd9999) ? 14'd9999 : score;
    assign busy        = (r_state != S_IDLE);

    // BCD field occupies r_shift[29:14]; correct each nibble before the shift.
    always_comb begin
        w_adj = r_shift;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_shift[14 + 4*i +: 4] >= 4'd5) begin
                w_adj[14 + 4*i +: 4] = r_shift[14 + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_iter     <= '0;
            r_shift    <= '0;
            r_pending  <= 1'b0;
            r_pend_val <= '0;
            r_digits   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift   <= {16'h0000, w_score_sat};
                        r_iter    <= '0;
                        r_pending <= 1'b0;
                        r_state   <= S_CONV;
                    end else if (r_pending) begin
                        r_shift   <= {16'h0000, r_pend_val};
                        r_iter    <= '0;
                        r_pending <= 1'b0;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_adj << 1;
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == 4'd13) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_digits <= r_shift[29:14];
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Requests arriving mid-conversion are queued; newest overwrites.
            if (load && (r_state != S_IDLE)) begin
                r_pending  <= 1'b1;
                r_pend_val <= w_score_sat;
            end
        end
    end

    always_comb begin
        w_digit = r_digits[{r_slot, 2'b00} +: 4];
        case (r_slot)
            2'd1:    w_lz = (r_digits[15:4]  == '0);
            2'd2:    w_lz = (r_digits[15:8]  == '0);
            2'd3:    w_lz = (r_digits[15:12] == '0);
            default: w_lz = 1'b0;
        endcase
        w_slot_num = (BLANK_LZ && w_lz) ? 4'hF : w_digit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= '0;
            an     <= 4'b1110;
            num    <= 4'h0;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt  <= '0;
                r_slot <= r_slot + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            an  <= ~(4'b0001 << r_slot);
            num <= w_slot_num;
        end
    end

endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench: stimulus pushes the expected display per conversion; monitors
// detect completions (busy falling) and check a full scan rotation on two instances.
`timescale 1ns/1ps
module tb_score_display_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] score = '0;
    logic        busy, busy_nb;
    logic [3:0]  num, an, num_nb, an_nb;

    always #5 clk = ~clk;

    score_display_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .score(score), .load(load),
        .busy(busy), .num(num), .an(an)
    );

    score_display_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .score(score), .load(load),
        .busy(busy_nb), .num(num_nb), .an(an_nb)
    );

    typedef struct {
        logic [15:0] blank;
        logic [15:0] noblank;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   scanning = 1'b0;

    localparam int NV = 9;
    logic [13:0] v_score [NV] = '{14'd1234, 14'd7, 14'd0, 14'd1005, 14'd12000,
                                  14'd16383, 14'd9999, 14'd10000, 14'd10};
    logic [15:0] v_blank [NV] = '{16'h1234, 16'hFFF7, 16'hFFF0, 16'h1005, 16'h9999,
                                  16'h9999, 16'h9999, 16'h9999, 16'hFF10};
    logic [15:0] v_nobl  [NV] = '{16'h1234, 16'h0007, 16'h0000, 16'h1005, 16'h9999,
                                  16'h9999, 16'h9999, 16'h9999, 16'h0010};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_disp(input string name, input logic [15:0] b, input logic [15:0] nb);
        exp_t e;
        e.blank   = b;
        e.noblank = nb;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    task automatic pulse_load(input logic [13:0] s);
        score = s;
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0 || done_q.size() != 0 || scanning) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 400) chk("idle_timeout", k, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Busy-length monitor; a busy pulse cut short by reset is not a completion.
    initial begin : busy_mon
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else if (busy) begin
                cnt++;
            end else if (cnt != 0) begin
                chk("busy_len", cnt, 15);
                chk("busy_match_nb", busy_nb, busy);
                done_q.push_back(1);
                cnt = 0;
            end
        end
    end

    initial begin : scan_mon
        exp_t       e;
        logic [3:0] prev_an;
        int         hits [4];
        int         slot;
        forever begin
            @(negedge clk); #1;
            if (done_q.size() == 0) continue;
            void'(done_q.pop_front());
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 1, 0);
                continue;
            end
            e = exp_q.pop_front();
            scanning = 1'b1;
            foreach (hits[s]) hits[s] = 0;
            prev_an = 4'b0000;
            for (int i = 0; i < 4*DIV; i++) begin
                @(negedge clk);
                case (an)
                    4'b1110: slot = 0;
                    4'b1101: slot = 1;
                    4'b1011: slot = 2;
                    4'b0111: slot = 3;
                    default: slot = -1;
                endcase
                if (slot < 0) begin
                    chk({e.name, "_an_onehot"}, an, 4'b1110);
                end else begin
                    chk({e.name, "_num"}, num, e.blank[4*slot +: 4]);
                    chk({e.name, "_num_noblank"}, num_nb, e.noblank[4*slot +: 4]);
                    chk({e.name, "_an_noblank"}, an_nb, an);
                    hits[slot]++;
                end
                if (i > 0)
                    chk({e.name, "_an_order"},
                        (an == prev_an) || (an == {prev_an[2:0], prev_an[3]}), 1);
                prev_an = an;
            end
            for (int s = 0; s < 4; s++) chk({e.name, "_slot_dwell"}, hits[s], DIV);
            scanning = 1'b0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_an", an, 4'b1110);
        chk("reset_num", num, 4'h0);
        expect_disp("reset", 16'hFFF0, 16'h0000);
        done_q.push_back(1);
        wait_idle();

        for (int v = 0; v < NV; v++) begin
            expect_disp($sformatf("score%0d", v_score[v]), v_blank[v], v_nobl[v]);
            pulse_load(v_score[v]);
            chk("busy_after_load", busy, 1);
            wait_idle();
        end

        // 1234 runs to completion; 55 is overwritten by 66 before it starts.
        expect_disp("ovl_1234", 16'h1234, 16'h1234);
        expect_disp("ovl_66", 16'hFF66, 16'h0066);
        pulse_load(14'd1234);
        repeat (4) @(posedge clk);
        #1;
        pulse_load(14'd55);
        repeat (3) @(posedge clk);
        #1;
        pulse_load(14'd66);
        wait_idle();

        // Load landing exactly on the COMMIT cycle is queued.
        expect_disp("commit_80", 16'hFF80, 16'h0080);
        expect_disp("commit_100", 16'hF100, 16'h0100);
        pulse_load(14'd80);
        repeat (14) @(posedge clk);
        #1;
        pulse_load(14'd100);
        wait_idle();

        pulse_load(14'd4321);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_an", an, 4'b1110);
        chk("midrst_num", num, 4'h0);
        expect_disp("midrst", 16'hFFF0, 16'h0000);
        done_q.push_back(1);
        wait_idle();
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_still_idle", busy, 0);
        chk("leftover_completions", done_q.size(), 0);
        chk("leftover_expected", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
- Upstream feeder for the seven-segment digit decoder on the 4-digit display.
- Captures a binary score and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, one iteration per clock.
- Time-multiplexes the digits: drives the 4-bit digit code to the decoder and the active-low anode selects.
- Leading-zero blanking uses digit code 4'hF, which the decoder renders as all segments off.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (100 MHz gives 1 kHz per slot); legal range ≥ 2.
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show all four digits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- score  input  14  binary score; sampled only when a load is accepted
- load  input  1  single-cycle request to capture score and convert it
- busy  output  1  high while a conversion is in progress (CONV or COMMIT state)
- num  output  4  BCD digit code to the decoder; 4'hF means blank
- an  output  4  active-low anode one-hot; an[0] is the ones digit (rightmost)

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE, busy=0, pending=0.
  - Display digits d3..d0 = 0; refresh counter = 0; slot index = 0.
  - an=4'b1110, num=4'h0.
  - Reset mid-conversion discards the conversion and any pending request; the display shows 0.
- Capture:
  - Captured value = (score > 9999) ? 9999 : score.
  - Shift register = {16'h0000, captured[13:0]}, 30 bits.
- FSM:
  - IDLE: if load=1, capture score and go to CONV with iter=0. Else if pending=1, capture pend_val, clear pending, go to CONV. load has priority over pending and clears it.
  - CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift the whole register left by 1; iter++. After the iteration with iter=13 (14 iterations total), go to COMMIT.
  - COMMIT: copy the BCD nibbles to d3..d0; go to IDLE.
- Latency: load sampled at edge t → busy=1 after edge t → d3..d0 updated and busy=0 after edge t+15. num/an reflect the new digits from the next registered scan update.
- Load while busy (CONV or COMMIT, including the COMMIT cycle itself):
  - Saturate score into pend_val and set pending. A later load overwrites pend_val (newest wins).
  - The current conversion is never aborted.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, slot index advances 0→1→2→3→0.
  - an and num are registered, updated every cycle from the current slot index and d3..d0 (one-cycle latency).
  - Anode map: slot k drives an = ~(4'b0001 << k).
- Blanking (BLANK_LZ=1): for slot k ≥ 1, num=4'hF if d3..dk are all 0. Slot 0 is never blanked, so a score of 0 shows "0".
- d3..d0 change only in COMMIT. The scan runs independently of the converter and never stalls.

Test Plan (bench uses REFRESH_DIV=4, BLANK_LZ=1 unless stated):
- Reset: hold rst 2 cycles → an=4'b1110, num=0, busy=0. Scan cycles num 0,F,F,F with an 1110,1101,1011,0111.
- Load with score=1234 → busy high exactly 15 cycles. Scan then shows num 4,3,2,1 on an 1110,1101,1011,0111 and wraps back to 1110.
- Blanking: score=7 → num 7,F,F,F. Score=0 → num 0,F,F,F. Score=1005 → num 5,0,0,1 (embedded zeros shown). With BLANK_LZ=0, score=7 → num 7,0,0,0.
- Saturation: score=12000 or 16383 → num 9,9,9,9. Score=9999 → num 9,9,9,9.
- Overlap: load 1234; at busy cycle 5 load 55; at busy cycle 9 load 66.
  - Display first shows 1234.
  - A second conversion starts the cycle after COMMIT, and busy stays high for a further 15 cycles.
  - Final display is 66. 55 is never displayed.
- Reset mid-operation: load 4321, assert rst at busy cycle 7 → busy=0 and display shows 0. No later update to 4321 occurs.
